fetch_sched: RTL and testbench

FETCH_SCHED -- requirements
Module: fetch_sched

---
 rtl/fetch_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 58 +++++
 rtl/fetch_sched.sv | 129 ++++++++++++
 tb/tb_fetch_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch scheduler: FSM encoding and default sizing
// used by fetch_sched, its arbiter and the lane FIFO wrapper.
package fetch_pkg;

  localparam int DEF_LANES = 12;
  localparam int DEF_AW    = 10;
  localparam int DEF_DW    = 64;
  localparam int DEF_LW    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starts one past
// the last granted index; clear returns the search origin to index 0.
module rr_arbiter
  import fetch_pkg::*;
#(
  parameter  int N  = DEF_LANES,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  localparam int SW = IW + 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sum;
  logic [IW-1:0] idx;

  // ptr_q < N and off < N, so one conditional subtract is a full mod-N wrap
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + SW'(off);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[IW-1:0];
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (gnt_valid) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fetch_sched.sv
// Fetch scheduler: streams per-lane word runs from a synchronous ROM into lane
// FIFOs, one round-robin grant per cycle with a fixed 2-cycle issue-to-write latency.
module fetch_sched
  import fetch_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int LW    = DEF_LW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LANES*AW-1:0] cfg_base,
  input  logic [LANES*LW-1:0] cfg_len,
  input  logic [LANES-1:0]    lane_full,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [DW-1:0]       fifo_din,
  output logic [LANES-1:0]    fifo_wr_en,
  output logic                busy,
  output logic                done
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q    [LANES];
  logic [AW-1:0]    ptr_d    [LANES];
  logic [LW-1:0]    remain_q [LANES];
  logic [LW-1:0]    remain_d [LANES];
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [LANES-1:0] wr_s1_q, wr_s1_d;
  logic [LANES-1:0] wr_en_q, wr_en_d;

  logic [LANES-1:0] eligible;
  logic [LANES-1:0] gnt;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_idx;
  logic             all_zero;
  logic             in_flight;
  logic             arb_clear;
  logic             arb_en;

  // The two write-pipeline stages double as the "granted in the last two cycles" history
  always_comb begin
    eligible = '0;
    all_zero = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      eligible[i] = (remain_q[i] != '0) && !lane_full[i] && !wr_s1_q[i] && !wr_en_q[i];
      if (remain_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign in_flight = (wr_s1_q != '0) || (wr_en_q != '0);
  assign arb_clear = (state_q == ST_IDLE) && start;
  assign arb_en    = (state_q == ST_RUN);

  rr_arbiter #(.N(LANES)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .clear     (arb_clear),
    .en        (arb_en),
    .req       (eligible),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    rom_addr_d = rom_addr_q;
    wr_s1_d    = gnt;
    wr_en_d    = wr_s1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < LANES; i++) begin
            ptr_d[i]    = cfg_base[i*AW +: AW];
            remain_d[i] = cfg_len[i*LW +: LW];
          end
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (all_zero) begin
          state_d = ST_DRAIN;
        end else if (gnt_valid) begin
          rom_addr_d        = ptr_q[gnt_idx];
          ptr_d[gnt_idx]    = ptr_q[gnt_idx] + AW'(1);
          remain_d[gnt_idx] = remain_q[gnt_idx] - LW'(1);
        end
      end
      ST_DRAIN: begin
        if (!in_flight) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      wr_s1_q    <= '0;
      wr_en_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        ptr_q[i]    <= '0;
        remain_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      wr_s1_q    <= wr_s1_d;
      wr_en_q    <= wr_en_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign fifo_din   = rom_data;
  assign fifo_wr_en = wr_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DRAIN) && !in_flight;

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: a synchronous ROM model plus a write/done logger,
// with hand-computed write sequences checked after each scenario.
module tb_fetch_sched;

  localparam int LANES = 12;
  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int LW    = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [LANES*AW-1:0] cfg_base = '0;
  logic [LANES*LW-1:0] cfg_len = '0;
  logic [LANES-1:0]    lane_full = '0;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_data;
  logic [DW-1:0]       fifo_din;
  logic [LANES-1:0]    fifo_wr_en;
  logic                busy;
  logic                done;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int c1;
  int mon_lane;
  int w_bad = 0;
  int w_cyc [$];
  int w_lane [$];
  logic [DW-1:0] w_data [$];
  int d_cyc [$];

  int b_addr [3] = '{1023, 0, 1};
  int b_off  [3] = '{2, 5, 8};
  int c_off  [8] = '{2, 3, 6, 9, 12, 13, 16, 19};
  int c_lane [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  int c_addr [8] = '{100, 200, 201, 202, 203, 101, 102, 103};

  fetch_sched #(.LANES(LANES), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_len    (cfg_len),
    .lane_full  (lane_full),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, 22'h2AAAAA, 22'h0, a};
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  // Logs every write and done pulse in the middle of the cycle
  always @(negedge clk) begin
    if (fifo_wr_en != '0) begin
      mon_lane = -1;
      for (int i = 0; i < LANES; i++) if (fifo_wr_en[i]) mon_lane = i;
      if (!$onehot(fifo_wr_en)) w_bad++;
      w_cyc.push_back(cyc);
      w_lane.push_back(mon_lane);
      w_data.push_back(fifo_din);
    end
    if (done === 1'b1) d_cyc.push_back(cyc);
  end

  function automatic int get_cyc(input int k);
    return (k < w_cyc.size()) ? w_cyc[k] : -1000;
  endfunction

  function automatic int get_lane(input int k);
    return (k < w_lane.size()) ? w_lane[k] : -1;
  endfunction

  function automatic logic [DW-1:0] get_data(input int k);
    return (k < w_data.size()) ? w_data[k] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int get_done(input int k);
    return (k < d_cyc.size()) ? d_cyc[k] : -1000;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    cfg_base = '0;
    cfg_len  = '0;
  endtask

  task automatic set_lane(input int i, input int base, input int len);
    cfg_base[i*AW +: AW] = AW'(base);
    cfg_len[i*LW +: LW]  = LW'(len);
  endtask

  task automatic clear_log();
    w_cyc.delete();
    w_lane.delete();
    w_data.delete();
    d_cyc.delete();
    w_bad = 0;
  endtask

  task automatic pulse_start(output int c);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = cyc;
  endtask

  initial begin
    // Reset state
    tick();
    check_output("rst.rom_addr", rom_addr, 0);
    check_output("rst.wr_en", fifo_wr_en, 0);
    check_output("rst.busy", busy, 0);
    check_output("rst.done", done, 0);
    rst = 1'b0;
    tick();

    // A: all twelve lanes, base 16*i, two words each
    clear_cfg();
    for (int i = 0; i < LANES; i++) set_lane(i, 16 * i, 2);
    clear_log();
    pulse_start(c1);
    check_output("A.busy_run", busy, 1);
    repeat (40) tick();
    check_output("A.count", w_cyc.size(), 24);
    for (int k = 0; k < 24; k++) begin
      check_output($sformatf("A.lane%0d", k), get_lane(k), k % 12);
      check_output($sformatf("A.data%0d", k), get_data(k), rom_word(AW'(16 * (k % 12) + k / 12)));
      check_output($sformatf("A.cyc%0d", k), get_cyc(k) - c1, 2 + k);
    end
    check_output("A.done_n", d_cyc.size(), 1);
    check_output("A.done_cyc", get_done(0) - c1, 26);
    check_output("A.onehot", w_bad, 0);
    check_output("A.busy_end", busy, 0);

    // B: lane 5 alone, address wraps from 1023
    clear_cfg();
    set_lane(5, 1023, 3);
    clear_log();
    pulse_start(c1);
    repeat (15) tick();
    check_output("B.count", w_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("B.lane%0d", k), get_lane(k), 5);
      check_output($sformatf("B.data%0d", k), get_data(k), rom_word(AW'(b_addr[k])));
      check_output($sformatf("B.cyc%0d", k), get_cyc(k) - c1, b_off[k]);
    end
    check_output("B.done_cyc", get_done(0) - c1, 9);

    // C: lanes 0,1 with lane 0 full during run cycles 3..10
    clear_cfg();
    set_lane(0, 100, 4);
    set_lane(1, 200, 4);
    clear_log();
    pulse_start(c1);
    for (int k = 0; k < 30; k++) begin
      lane_full[0] = (k >= 3 && k <= 10);
      tick();
    end
    lane_full = '0;
    check_output("C.count", w_cyc.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check_output($sformatf("C.lane%0d", k), get_lane(k), c_lane[k]);
      check_output($sformatf("C.data%0d", k), get_data(k), rom_word(AW'(c_addr[k])));
      check_output($sformatf("C.cyc%0d", k), get_cyc(k) - c1, c_off[k]);
    end
    check_output("C.done_cyc", get_done(0) - c1, 20);

    // D: every lane inactive
    clear_cfg();
    clear_log();
    pulse_start(c1);
    repeat (6) tick();
    check_output("D.count", w_cyc.size(), 0);
    check_output("D.done_n", d_cyc.size(), 1);
    check_output("D.done_in_time", (get_done(0) - c1 >= 0) && (get_done(0) - c1 <= 2), 1);
    check_output("D.busy_end", busy, 0);

    // E: reset one cycle after the first grant, then a fresh run
    clear_cfg();
    set_lane(0, 300, 2);
    set_lane(3, 40, 1);
    clear_log();
    pulse_start(c1);
    tick();
    check_output("E.addr_pre", rom_addr, 300);
    rst = 1'b1;
    #1;
    check_output("E.rst_addr", rom_addr, 0);
    check_output("E.rst_wr_en", fifo_wr_en, 0);
    check_output("E.rst_busy", busy, 0);
    check_output("E.rst_done", done, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check_output("E.no_writes", w_cyc.size(), 0);
    check_output("E.no_done", d_cyc.size(), 0);
    check_output("E.busy_idle", busy, 0);
    clear_cfg();
    set_lane(2, 50, 1);
    set_lane(7, 60, 1);
    clear_log();
    pulse_start(c1);
    repeat (10) tick();
    check_output("E2.count", w_cyc.size(), 2);
    check_output("E2.lane0", get_lane(0), 2);
    check_output("E2.data0", get_data(0), rom_word(AW'(50)));
    check_output("E2.cyc0", get_cyc(0) - c1, 2);
    check_output("E2.lane1", get_lane(1), 7);
    check_output("E2.data1", get_data(1), rom_word(AW'(60)));
    check_output("E2.cyc1", get_cyc(1) - c1, 3);
    check_output("E2.done_cyc", get_done(0) - c1, 4);

    // F: a second start during RUN must be ignored
    clear_cfg();
    for (int j = 0; j < 3; j++) set_lane(j, 100 * j, 3);
    clear_log();
    pulse_start(c1);
    repeat (2) tick();
    for (int j = 0; j < LANES; j++) set_lane(j, 500, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check_output("F.count", w_cyc.size(), 9);
    for (int k = 0; k < 9; k++) begin
      check_output($sformatf("F.lane%0d", k), get_lane(k), k % 3);
      check_output($sformatf("F.data%0d", k), get_data(k), rom_word(AW'(100 * (k % 3) + k / 3)));
      check_output($sformatf("F.cyc%0d", k), get_cyc(k) - c1, 2 + k);
    end
    check_output("F.done_n", d_cyc.size(), 1);
    check_output("F.done_cyc", get_done(0) - c1, 11);
    check_output("F.busy_end", busy, 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
